str_hb_deci_mc: RTL

Streaming half-band decimate-by-2 filter for NCH time-interleaved channels. It replaces the separate FIR plus decimator pairs in the down-sampling chain with one resource-shared stage. The filter uses a single sequential multiply-accumulate (MAC) that exploits half-band symmetry and zero taps. It adds a runtime bypass, per-channel phase tracking, channel tagging on `m_axis_tuser`, and tlast framing.

---
 rtl/str_hb_deci_mc.sv | 105 ++++++++++
 1 files changed

// File: rtl/str_hb_deci_mc.sv
// str_hb_deci_mc: multichannel half-band decimate-by-2 filter with a shared symmetric MAC, bypass and tlast framing
module str_hb_deci_mc #(
  parameter int DW = 24,
  parameter int CW = 18,
  parameter int NCH = 1,
  parameter int NTAP = 7,
  parameter logic signed [CW-1:0] COEF [(NTAP-3)/4+1] = '{-18'sd4096, 18'sd36864},
  parameter int FRAME = 16000
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    bypass,
  input  logic [DW-1:0]                           s_axis_tdata,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  output logic [DW-1:0]                           m_axis_tdata,
  output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0]  m_axis_tuser,
  output logic                                    m_axis_tlast,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready
);
  localparam int K = (NTAP - 3) / 4;
  localparam int UW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int AW = DW + CW + 1 + $clog2(K + 2);
  localparam int PW = DW + CW + 1;
  localparam int MW = $clog2(K + 1);
  localparam int TW = $clog2(NTAP);
  localparam int FW = FRAME > 1 ? $clog2(FRAME) : 1;
  localparam int CI = (NTAP - 1) / 2;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_n;
  logic signed [DW-1:0] dl [NCH][NTAP];
  logic [NCH-1:0] phase;
  logic [UW-1:0] ich, och;
  logic [MW-1:0] mi;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] ia, ib;
  logic signed [AW-1:0] acc, acc_n, cen, rnd;
  logic signed [PW-1:0] prod;
  logic signed [DW:0] pair;
  logic [DW-1:0] sat;
  logic in_hs, out_hs, last;
  assign s_axis_tready = state == IDLE;
  assign m_axis_tvalid = state == OUT;
  assign in_hs = s_axis_tvalid && s_axis_tready;
  assign out_hs = m_axis_tvalid && m_axis_tready;
  assign last = state == MAC && mi == MW'(K);
  assign m_axis_tlast = m_axis_tvalid && FRAME != 0 && fcnt == FW'(FRAME - 1);
  // one symmetric pair per MAC cycle; the center tap joins on the final cycle
  always_comb begin
    ia = TW'(2 * mi);
    ib = TW'(NTAP - 1 - 2 * mi);
    pair = {dl[och][ia][DW-1], dl[och][ia]} + {dl[och][ib][DW-1], dl[och][ib]};
    prod = PW'(pair) * PW'(COEF[mi]);
    cen = AW'(dl[och][CI]) <<< (CW - 2);
    acc_n = acc + AW'(prod) + (last ? cen : AW'(0));
    rnd = (acc_n + (AW'(1) <<< (CW - 2))) >>> (CW - 1);
    sat = (&rnd[AW-1:DW-1] || ~|rnd[AW-1:DW-1]) ? rnd[DW-1:0] : {rnd[AW-1], {(DW-1){~rnd[AW-1]}}};
  end
  always_comb begin
    state_n = state;
    if (in_hs) state_n = bypass ? OUT : phase[ich] ? MAC : IDLE;
    else if (last) state_n = OUT;
    else if (out_hs) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ich <= '0;
      och <= '0;
      mi <= '0;
      fcnt <= '0;
      acc <= '0;
      phase <= '0;
      m_axis_tdata <= '0;
      m_axis_tuser <= '0;
      for (int c = 0; c < NCH; c++)
        for (int j = 0; j < NTAP; j++) dl[c][j] <= '0;
    end else begin
      state <= state_n;
      if (in_hs) begin
        ich <= ich == UW'(NCH - 1) ? '0 : ich + UW'(1);
        if (bypass) begin
          m_axis_tdata <= s_axis_tdata;
          m_axis_tuser <= ich;
        end else begin
          for (int j = NTAP - 1; j > 0; j--) dl[ich][j] <= dl[ich][j-1];
          dl[ich][0] <= s_axis_tdata;
          phase[ich] <= ~phase[ich];
          och <= ich;
          acc <= '0;
          mi <= '0;
        end
      end
      if (state == MAC) begin
        acc <= acc_n;
        mi <= mi + MW'(1);
      end
      if (last) begin
        m_axis_tdata <= sat;
        m_axis_tuser <= och;
      end
      if (out_hs) fcnt <= fcnt == FW'(FRAME - 1) ? '0 : fcnt + FW'(1);
    end
endmodule
